ps2_kbd_decoder: RTL and testbench

- Sits directly downstream of ps2_rx, in the clk_100mhz domain.
- Consumes the raw PS/2 Set-2 scancode byte stream and collapses multi-byte sequences into single key events: make/break, normal/extended, and the E1 Pause sequence.
- Buffers the key events in a FWFT FIFO, which the RISC-V core (via MMIO glue) or debug logic pops.

---
 rtl/ps2_pkg.sv | 47 ++++
 rtl/sync_fifo.sv | 49 ++++
 rtl/ps2_kbd_decoder.sv | 177 +++++++++++++++++
 tb/tb_ps2_kbd_decoder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 Set-2 keyboard decoder.
package ps2_pkg;

    typedef struct packed {
        logic       released;
        logic       extended;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } kbd_state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    // Keyboard status/response bytes that never represent a key.
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_LGUI   = 8'h1F;
    localparam logic [7:0] SC_RGUI   = 8'h27;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    function automatic logic is_filtered(input logic [7:0] c);
        return (c == SC_ERR0) || (c == SC_BAT_OK) || (c == SC_ACK) ||
               (c == SC_RESEND) || (c == SC_ERR1);
    endfunction

    function automatic logic is_shift(input logic [7:0] c);
        return (c == SC_LSHIFT) || (c == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Collapses PS/2 Set-2 scancode sequences into key events buffered in a FWFT FIFO.
// Define PS2_KBD_MODIFIERS_EN to enable held-modifier tracking on mods_out.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    input  logic [7:0]       scancode_in,
    input  logic             error_in,
    input  logic             event_ready_in,
    output logic             event_valid_out,
    output logic [9:0]       event_data_out,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow_out,
    output logic [3:0]       mods_out
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    kbd_state_e state, state_next;
    logic [2:0] skip_cnt, skip_next;
    logic       vld_p0;
    kbd_event_t evt_p0;
    logic       vld_p1;
    kbd_event_t evt_p1;

    logic [9:0]     head;
    logic [FCW-1:0] fifo_count;
    logic           fifo_full;
    logic           fifo_empty;

    always_comb begin
        state_next      = state;
        skip_next       = skip_cnt;
        vld_p0          = 1'b0;
        evt_p0.released = 1'b0;
        evt_p0.extended = 1'b0;
        evt_p0.code     = scancode_in;
        if (error_in) begin
            state_next = ST_IDLE;
        end else if (valid_in) begin
            case (state)
                ST_IDLE: begin
                    if (scancode_in == SC_EXT) begin
                        state_next = ST_EXT;
                    end else if (scancode_in == SC_BRK) begin
                        state_next = ST_BRK;
                    end else if (scancode_in == SC_PAUSE) begin
                        state_next = ST_PAUSE;
                        skip_next  = PAUSE_SKIP;
                    end else if (!is_filtered(scancode_in)) begin
                        vld_p0 = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (scancode_in == SC_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else begin
                        state_next      = ST_IDLE;
                        vld_p0          = !is_shift(scancode_in);
                        evt_p0.extended = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_next      = ST_IDLE;
                    vld_p0          = 1'b1;
                    evt_p0.released = 1'b1;
                end
                ST_EXT_BRK: begin
                    state_next      = ST_IDLE;
                    vld_p0          = !is_shift(scancode_in);
                    evt_p0.released = 1'b1;
                    evt_p0.extended = 1'b1;
                end
                ST_PAUSE: begin
                    skip_next = skip_cnt - 1'b1;
                    if (skip_cnt == 3'd1) begin
                        state_next      = ST_IDLE;
                        vld_p0          = 1'b1;
                        evt_p0.extended = 1'b1;
                        evt_p0.code     = SC_PAUSE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            vld_p1   <= 1'b0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            vld_p1   <= vld_p0;
        end
    end

    // p0 -> p1: decoded event registered before entering the FIFO
    always_ff @(posedge clk_in) begin
        evt_p1 <= evt_p0;
    end

    sync_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_in),
        .push      (vld_p1),
        .push_data (evt_p1),
        .pop       (event_ready_in),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign event_valid_out = !fifo_empty;
    assign event_data_out  = fifo_empty ? 10'd0 : head;
    assign count_out       = CNT_W'(fifo_count);

    // A full FIFO with a pending pop still takes the write, so only drop without ready.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            overflow_out <= 1'b0;
        end else if (vld_p1 && fifo_full && !event_ready_in) begin
            overflow_out <= 1'b1;
        end
    end

`ifdef PS2_KBD_MODIFIERS_EN
    logic shift_l, shift_r, ctrl_l, ctrl_r, alt_l, alt_r, gui_l, gui_r;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            ctrl_l  <= 1'b0;
            ctrl_r  <= 1'b0;
            alt_l   <= 1'b0;
            alt_r   <= 1'b0;
            gui_l   <= 1'b0;
            gui_r   <= 1'b0;
        end else if (vld_p1) begin
            if (!evt_p1.extended) begin
                case (evt_p1.code)
                    SC_LSHIFT: shift_l <= !evt_p1.released;
                    SC_RSHIFT: shift_r <= !evt_p1.released;
                    SC_CTRL:   ctrl_l  <= !evt_p1.released;
                    SC_ALT:    alt_l   <= !evt_p1.released;
                    default: ;
                endcase
            end else begin
                case (evt_p1.code)
                    SC_CTRL: ctrl_r <= !evt_p1.released;
                    SC_ALT:  alt_r  <= !evt_p1.released;
                    SC_LGUI: gui_l  <= !evt_p1.released;
                    SC_RGUI: gui_r  <= !evt_p1.released;
                    default: ;
                endcase
            end
        end
    end

    assign mods_out = {gui_l | gui_r, alt_l | alt_r, ctrl_l | ctrl_r, shift_l | shift_r};
`else
    assign mods_out = 4'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench for ps2_kbd_decoder: expected events queued at stimulus, checked on pop.
module tb_ps2_kbd_decoder;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PS2_KBD_MODIFIERS_EN
    localparam bit MODS = 1'b1;
`else
    localparam bit MODS = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          valid_in = 1'b0;
    logic [7:0]    scancode_in = 8'h00;
    logic          error_in = 1'b0;
    logic          event_ready_in = 1'b0;
    logic          event_valid_out;
    logic [9:0]    event_data_out;
    logic [CW-1:0] count_out;
    logic          overflow_out;
    logic [3:0]    mods_out;

    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;
    int vectors = 0;
    int miscompares = 0;

    ps2_kbd_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .valid_in        (valid_in),
        .scancode_in     (scancode_in),
        .error_in        (error_in),
        .event_ready_in  (event_ready_in),
        .event_valid_out (event_valid_out),
        .event_data_out  (event_data_out),
        .count_out       (count_out),
        .overflow_out    (overflow_out),
        .mods_out        (mods_out)
    );

    always #5 clk_in = ~clk_in;

    // Every handshake seen at the falling edge is compared against the queue head.
    always @(negedge clk_in) begin
        if (rst_in && event_valid_out && event_ready_in) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got %h, expected no event", event_data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (event_data_out !== mon_exp) begin
                    miscompares++;
                    $display("FAIL event_data: got %h, expected %h", event_data_out, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        valid_in    = 1'b1;
        scancode_in = b;
        @(posedge clk_in); #1;
        valid_in    = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        settle();
        while ((exp_q.size() != 0 || event_valid_out) && n < 64) begin
            @(posedge clk_in); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0; valid_in = 1'b0; error_in = 1'b0; event_ready_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        exp_q.delete();
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (event_valid_out !== 1'b0 || event_data_out !== 10'd0 || count_out !== '0 ||
            overflow_out !== 1'b0 || mods_out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data=%h count=%0d ovf=%b mods=%b, expected all 0",
                     event_valid_out, event_data_out, count_out, overflow_out, mods_out);
        end
    endtask

    task automatic test_make_break();
        event_ready_in = 1'b0;
        send_byte(8'h1C);
        @(negedge clk_in);
        vectors++;
        if (event_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL make_latency_early: valid=%b, expected 0", event_valid_out);
        end
        @(negedge clk_in);
        vectors++;
        if (event_valid_out !== 1'b1 || event_data_out !== 10'h01C) begin
            miscompares++;
            $display("FAIL make_latency: valid=%b data=%h, expected 1/01c", event_valid_out, event_data_out);
        end
        exp_q.push_back(10'h01C);
        @(posedge clk_in); #1;
        event_ready_in = 1'b1;
        exp_q.push_back(10'h21C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        @(negedge clk_in);
        vectors++;
        if (event_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL break_latency_early: valid=%b, expected 0", event_valid_out);
        end
        wait_idle();
        vectors++;
        if (count_out !== '0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL make_break_drain: count=%0d pending=%0d, expected 0/0", count_out, exp_q.size());
        end
    endtask

    task automatic test_extended();
        event_ready_in = 1'b1;
        exp_q.push_back(10'h175);
        exp_q.push_back(10'h375);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'h59);
        wait_idle();
        vectors++;
        if (count_out !== '0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL extended_drain: count=%0d pending=%0d, expected 0/0", count_out, exp_q.size());
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        event_ready_in = 1'b1;
        exp_q.push_back(10'h1E1);
        exp_q.push_back(10'h01C);
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        send_byte(8'h1C);
        wait_idle();
        vectors++;
        if (count_out !== '0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pause_drain: count=%0d pending=%0d, expected 0/0", count_out, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        event_ready_in = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) exp_q.push_back({2'b00, 8'(8'h20 + i)});
            send_byte(8'(8'h20 + i));
        end
        settle();
        vectors++;
        if (count_out !== CW'(DEPTH) || overflow_out !== 1'b1 || event_data_out !== 10'h020) begin
            miscompares++;
            $display("FAIL overflow_full: count=%0d ovf=%b head=%h, expected %0d/1/020",
                     count_out, overflow_out, event_data_out, DEPTH);
        end
        exp_q.push_back(10'h031);
        send_byte(8'h31);
        event_ready_in = 1'b1;
        @(posedge clk_in); #1;
        event_ready_in = 1'b0;
        settle();
        vectors++;
        if (count_out !== CW'(DEPTH) || overflow_out !== 1'b1 || event_data_out !== 10'h021) begin
            miscompares++;
            $display("FAIL full_push_pop: count=%0d ovf=%b head=%h, expected %0d/1/021",
                     count_out, overflow_out, event_data_out, DEPTH);
        end
        event_ready_in = 1'b1;
        wait_idle();
        vectors++;
        if (count_out !== '0 || exp_q.size() != 0 || overflow_out !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drain: count=%0d pending=%0d ovf=%b, expected 0/0/1",
                     count_out, exp_q.size(), overflow_out);
        end
        do_reset();
        vectors++;
        if (overflow_out !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_reset: ovf=%b, expected 0", overflow_out);
        end
    endtask

    task automatic test_error();
        event_ready_in = 1'b1;
        exp_q.push_back(10'h01C);
        exp_q.push_back(10'h01C);
        send_byte(8'hE0);
        error_in = 1'b1;
        @(posedge clk_in); #1;
        error_in = 1'b0;
        send_byte(8'h1C);
        error_in = 1'b1;
        send_byte(8'hF0);
        error_in = 1'b0;
        send_byte(8'h1C);
        wait_idle();
        vectors++;
        if (count_out !== '0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL error_drain: count=%0d pending=%0d, expected 0/0", count_out, exp_q.size());
        end
    endtask

    task automatic test_filtered();
        event_ready_in = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'hFE);
        send_byte(8'h00);
        wait_idle();
        vectors++;
        if (count_out !== '0 || event_valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL filtered: count=%0d valid=%b, expected 0/0", count_out, event_valid_out);
        end
    endtask

    task automatic test_reset_mid();
        event_ready_in = 1'b1;
        send_byte(8'hF0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        vectors++;
        if (event_valid_out !== 1'b0 || event_data_out !== 10'd0 || count_out !== '0 ||
            overflow_out !== 1'b0 || mods_out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: valid=%b data=%h count=%0d ovf=%b mods=%b, expected all 0",
                     event_valid_out, event_data_out, count_out, overflow_out, mods_out);
        end
        rst_in = 1'b1;
        exp_q.push_back(10'h01C);
        send_byte(8'h1C);
        wait_idle();
        vectors++;
        if (count_out !== '0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid_drain: count=%0d pending=%0d, expected 0/0", count_out, exp_q.size());
        end
    endtask

    task automatic test_modifiers();
        logic [7:0] bytes [10];
        logic [3:0] exp_m [10];
        logic [9:0] evts [6];
        bytes = '{8'h12, 8'h59, 8'hF0, 8'h12, 8'hF0, 8'h59, 8'hE0, 8'h14, 8'hE0, 8'h11};
        exp_m = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                  4'b0000, 4'b0010, 4'b0010, 4'b0110};
        evts  = '{10'h012, 10'h059, 10'h212, 10'h259, 10'h114, 10'h111};
        event_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(evts[i]);
        for (int i = 0; i < 10; i++) begin
            send_byte(bytes[i]);
            settle();
            vectors++;
            if (mods_out !== (MODS ? exp_m[i] : 4'b0000)) begin
                miscompares++;
                $display("FAIL mods_step%0d: got %b, expected %b", i, mods_out,
                         MODS ? exp_m[i] : 4'b0000);
            end
        end
        wait_idle();
        vectors++;
        if (count_out !== '0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mods_drain: count=%0d pending=%0d, expected 0/0", count_out, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_overflow();
        test_error();
        test_filtered();
        test_reset_mid();
        test_modifiers();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
